// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel arbiter: state encoding,
// default widths and an index-width helper.
package dma_pkg;

  localparam int DMA_ADDR_WIDTH = 32;
  localparam int DMA_SIZE_WIDTH = 32;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_LAUNCH = 2'd1;
  localparam logic [1:0] ARB_RUN    = 2'd2;
  localparam logic [1:0] ARB_DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ARB_IDLE,
    S_LAUNCH = ARB_LAUNCH,
    S_RUN    = ARB_RUN,
    S_DRAIN  = ARB_DRAIN
  } arb_state_e;

  // Width of a channel index; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_rr_pick.sv
// rr_pick: combinational circular priority picker. Returns the first
// requester at or after i_ptr (wrapping), as one-hot and as an index.
module rr_pick
  import dma_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;

  // Rotate requests so bit 0 is the channel at i_ptr.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated vector is the winner's offset from i_ptr.
  always_comb begin
    // NOTE: default first so w_off is driven on every path; no latch is inferred.
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  // Undo the rotation: index = (ptr + offset) mod N.
  assign w_sum    = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx    = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  assign o_valid  = |i_req;
  assign o_onehot = o_valid ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: round-robin sharing of one DMA engine between
// NUM_CH descriptor requesters. Latches the winner's descriptor, holds
// dma_start until dma_done, then pulses per-channel done/error.
// Optional feature macro: DMA_ARB_PRIO_EN adds ch_hipri; high-priority
// requesters are arbitrated round-robin among themselves and beat the rest.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
  parameter int SIZE_WIDTH = DMA_SIZE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef DMA_ARB_PRIO_EN
  input  logic [NUM_CH-1:0]            ch_hipri,
`endif
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] ch_size,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_err,
  output logic                         dma_start,
  output logic [ADDR_WIDTH-1:0]        src_addr,
  output logic [ADDR_WIDTH-1:0]        dst_addr,
  output logic [SIZE_WIDTH-1:0]        transfer_size,
  input  logic                         dma_done,
  input  logic                         dma_error,
  output logic                         busy
);

  localparam int IW = idx_width(NUM_CH);

  arb_state_e r_state, w_next_state;
  logic [IW-1:0]         r_rr_ptr;
  logic [NUM_CH-1:0]     r_grant, r_done, r_err;
  logic                  r_start, r_err_seen;
  logic [ADDR_WIDTH-1:0] r_src, r_dst;
  logic [SIZE_WIDTH-1:0] r_size;

  logic [NUM_CH-1:0]     w_pick_oh;
  logic [IW-1:0]         w_pick_idx, w_ptr_nxt;
  logic                  w_pick_valid;
  logic [ADDR_WIDTH-1:0] w_src, w_dst;
  logic [SIZE_WIDTH-1:0] w_size;

`ifdef DMA_ARB_PRIO_EN
  logic [NUM_CH-1:0] w_hi_oh, w_lo_oh;
  logic [IW-1:0]     w_hi_idx, w_lo_idx;
  logic              w_hi_valid, w_lo_valid;

  rr_pick #(.N(NUM_CH), .IW(IW)) u_pick_hi (
    .i_req(ch_req & ch_hipri), .i_ptr(r_rr_ptr),
    .o_onehot(w_hi_oh), .o_idx(w_hi_idx), .o_valid(w_hi_valid)
  );

  rr_pick #(.N(NUM_CH), .IW(IW)) u_pick_lo (
    .i_req(ch_req), .i_ptr(r_rr_ptr),
    .o_onehot(w_lo_oh), .o_idx(w_lo_idx), .o_valid(w_lo_valid)
  );

  // Any high-priority requester wins; otherwise plain round-robin over all.
  assign w_pick_oh    = w_hi_valid ? w_hi_oh  : w_lo_oh;
  assign w_pick_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
  assign w_pick_valid = w_lo_valid;
`else
  rr_pick #(.N(NUM_CH), .IW(IW)) u_pick (
    .i_req(ch_req), .i_ptr(r_rr_ptr),
    .o_onehot(w_pick_oh), .o_idx(w_pick_idx), .o_valid(w_pick_valid)
  );
`endif

  // Winner's slot in the packed descriptor buses.
  always_comb begin
    w_src  = '0;
    w_dst  = '0;
    w_size = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pick_idx == IW'(i)) begin
        w_src  = ch_src[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_dst  = ch_dst[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_size = ch_size[i*SIZE_WIDTH +: SIZE_WIDTH];
      end
    end
  end

  // Last winner gets lowest priority in the next round.
  assign w_ptr_nxt = (w_pick_idx == IW'(NUM_CH - 1)) ? '0 : w_pick_idx + 1'b1;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_pick_valid) w_next_state = S_LAUNCH;
      S_LAUNCH: w_next_state = (r_size == '0) ? S_IDLE : S_RUN;
      S_RUN:    if (dma_done) w_next_state = S_DRAIN;
      S_DRAIN:  if (!dma_done) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Grant, descriptor latch, engine handshake and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the descriptor latch is plain flops, not a memory, so it is reset with everything else.
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_start    <= 1'b0;
      r_err_seen <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_size     <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_grant    <= w_pick_oh;
            r_rr_ptr   <= w_ptr_nxt;
            r_src      <= w_src;
            r_dst      <= w_dst;
            r_size     <= w_size;
            r_err_seen <= 1'b0;
          end
        end
        S_LAUNCH: begin
          if (r_size == '0) begin
            // Empty descriptor: complete with error, engine untouched.
            r_done  <= r_grant;
            r_err   <= r_grant;
            r_grant <= '0;
          end else begin
            r_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (dma_error) r_err_seen <= 1'b1;
          if (dma_done) begin
            r_start <= 1'b0;
            r_done  <= r_grant;
            r_err   <= (r_err_seen || dma_error) ? r_grant : '0;
          end
        end
        S_DRAIN: begin
          if (!dma_done) begin
            r_grant    <= '0;
            r_err_seen <= 1'b0;
          end
        end
        default: begin
          r_grant    <= '0;
          r_start    <= 1'b0;
          r_err_seen <= 1'b0;
        end
      endcase
    end
  end

  assign ch_grant      = r_grant;
  assign ch_done       = r_done;
  assign ch_err        = r_err;
  assign dma_start     = r_start;
  assign src_addr      = r_src;
  assign dst_addr      = r_dst;
  assign transfer_size = r_size;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: directed steps push expected
// completions to a scoreboard; a monitor pops and compares on each ch_done.
// Define DMA_ARB_PRIO_EN to also exercise the high-priority class.
module tb_dma_channel_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int SW  = 32;
  localparam int ENG_LAT = 4;

  typedef struct {
    logic [NCH-1:0] oh;
    logic           err;
    logic [AW-1:0]  src;
    logic [AW-1:0]  dst;
    logic [SW-1:0]  size;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
`ifdef DMA_ARB_PRIO_EN
  logic [NCH-1:0]    ch_hipri;
`endif
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_src, ch_dst;
  logic [NCH*SW-1:0] ch_size;
  logic [NCH-1:0]    ch_grant, ch_done, ch_err;
  logic              dma_start, dma_done, dma_error, busy;
  logic [AW-1:0]     src_addr, dst_addr;
  logic [SW-1:0]     transfer_size;

  logic [AW-1:0] src_tab  [NCH];
  logic [AW-1:0] dst_tab  [NCH];
  logic [SW-1:0] size_tab [NCH];

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_cnt = 0;
  bit   inj_err = 1'b0;

  always #5 clk = ~clk;

  dma_channel_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DMA_ARB_PRIO_EN
    .ch_hipri(ch_hipri),
`endif
    .ch_req(ch_req), .ch_src(ch_src), .ch_dst(ch_dst), .ch_size(ch_size),
    .ch_grant(ch_grant), .ch_done(ch_done), .ch_err(ch_err),
    .dma_start(dma_start), .src_addr(src_addr), .dst_addr(dst_addr),
    .transfer_size(transfer_size), .dma_done(dma_done), .dma_error(dma_error),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_desc();
    for (int i = 0; i < NCH; i++) begin
      ch_src[i*AW +: AW]  = src_tab[i];
      ch_dst[i*AW +: AW]  = dst_tab[i];
      ch_size[i*SW +: SW] = size_tab[i];
    end
  endtask

  task automatic push_exp(input int ch, input bit err);
    exp_t e;
    e.oh   = NCH'(1) << ch;
    e.err  = err;
    e.src  = src_tab[ch];
    e.dst  = dst_tab[ch];
    e.size = size_tab[ch];
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (ch_done == '0 && n < 200);
    check(tag, 64'(ch_done != '0), 64'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (!dma_start && n < 200);
    check(tag, 64'(dma_start), 64'd1);
  endtask

  // Engine model: done after ENG_LAT cycles of dma_start, held until start drops.
  initial begin
    int eng_cnt = 0;
    dma_done = 1'b0;
    dma_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        dma_done = 1'b0; dma_error = 1'b0; eng_cnt = 0;
      end else if (dma_start && !dma_done) begin
        eng_cnt++;
        dma_error = inj_err && (eng_cnt == 2);
        if (eng_cnt == ENG_LAT) dma_done = 1'b1;
      end else if (!dma_start) begin
        dma_done = 1'b0; dma_error = 1'b0; eng_cnt = 0;
      end
    end
  end

  // Monitor: counts engine launches and scores every completion pulse.
  initial begin
    exp_t e;
    logic prev_start = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_start = 1'b0;
      end else begin
        if (dma_start && !prev_start) start_cnt++;
        prev_start = dma_start;
        if (ch_done != '0) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            check("done_onehot", 64'(ch_done), 64'(e.oh));
            check("err_pulse", 64'(ch_err), 64'(e.err ? e.oh : '0));
            check("src_addr", 64'(src_addr), 64'(e.src));
            check("dst_addr", 64'(dst_addr), 64'(e.dst));
            check("xfer_size", 64'(transfer_size), 64'(e.size));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    rst_n = 1'b0;
    ch_req = '0;
`ifdef DMA_ARB_PRIO_EN
    ch_hipri = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      src_tab[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
      dst_tab[i]  = 32'h2000_0000 + 32'(i) * 32'h100;
      size_tab[i] = 32'd64 * 32'(i + 1);
    end
    drive_desc();
    repeat (3) @(posedge clk);
    #2;

    // Reset state.
    check("rst_grant", 64'(ch_grant), 64'd0);
    check("rst_start", 64'(dma_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_src", 64'(src_addr), 64'd0);
    check("rst_size", 64'(transfer_size), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single channel, size 64; descriptor changed after grant must be ignored.
    ch_req = 4'b0001;
    push_exp(0, 1'b0);
    @(posedge clk); #2;
    check("t1_grant_lat1", 64'(ch_grant), 64'b0001);
    check("t1_start_launch", 64'(dma_start), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    src_tab[0] = 32'hDEAD_BEEF;
    drive_desc();
    @(posedge clk); #2;
    check("t1_start_run", 64'(dma_start), 64'd1);
    ch_req = '0;  // dropping the request must not abort
    wait_done("t1_done_seen");
    check("t1_start_dropped", 64'(dma_start), 64'd0);
    check("t1_busy_drain", 64'(busy), 64'd1);
    @(posedge clk); #2;
    check("t1_busy_idle", 64'(busy), 64'd0);
    check("t1_grant_clear", 64'(ch_grant), 64'd0);
    check("t1_done_once", 64'(ch_done), 64'd0);
    src_tab[0] = 32'h1000_0000;
    drive_desc();

    // Zero size on channel 2: done+err, engine never started.
    size_tab[2] = '0;
    drive_desc();
    s0 = start_cnt;
    ch_req = 4'b0100;
    push_exp(2, 1'b1);
    @(posedge clk); #2;
    check("t2_grant", 64'(ch_grant), 64'b0100);
    ch_req = '0;
    wait_done("t2_done_seen");
    check("t2_no_start", 64'(start_cnt - s0), 64'd0);
    size_tab[2] = 32'd192;
    drive_desc();
    @(posedge clk); #2;

    // Engine error on channel 1, then clean transfer on channel 3.
    inj_err = 1'b1;
    ch_req = 4'b0010;
    push_exp(1, 1'b1);
    @(posedge clk); #2;
    check("t3_grant", 64'(ch_grant), 64'b0010);
    ch_req = '0;
    wait_done("t3_done_seen");
    inj_err = 1'b0;
    @(posedge clk); #2;
    ch_req = 4'b1000;
    push_exp(3, 1'b0);
    @(posedge clk); #2;
    ch_req = '0;
    wait_done("t4_done_seen");
    @(posedge clk); #2;

    // Fairness: pointer is now 0, all four request for 8 transfers.
    ch_req = 4'b1111;
    for (int k = 0; k < 8; k++) push_exp(k % NCH, 1'b0);
    for (int k = 0; k < 8; k++) wait_done("t5_done_seen");
    ch_req = '0;
    repeat (2) @(posedge clk); #2;
    check("t5_sb_drained", 64'(sb_q.size()), 64'd0);

`ifdef DMA_ARB_PRIO_EN
    // High-priority channel 2 wins every arbitration while requesting.
    ch_hipri = 4'b0100;
    ch_req = 4'b1111;
    for (int k = 0; k < 3; k++) push_exp(2, 1'b0);
    for (int k = 0; k < 3; k++) wait_done("t7_done_seen");
    ch_req = '0;
    ch_hipri = '0;
    repeat (2) @(posedge clk); #2;
`endif

    // Reset mid-RUN on channel 2 (pointer moves to 3).
    ch_req = 4'b0100;
    @(posedge clk); #2;
    check("t6_grant", 64'(ch_grant), 64'b0100);
    ch_req = '0;
    wait_start("t6_start_seen");
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", 64'(ch_grant), 64'd0);
    check("t6_rst_start", 64'(dma_start), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_src", 64'(src_addr), 64'd0);
    check("t6_rst_dst", 64'(dst_addr), 64'd0);
    check("t6_rst_size", 64'(transfer_size), 64'd0);
    // Channel 3 also pending: a pointer surviving reset would pick it.
    ch_req = 4'b1010;
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    push_exp(1, 1'b0);
    @(posedge clk); #2;
    check("t6_grant_after_rst", 64'(ch_grant), 64'b0010);
    ch_req = '0;
    wait_done("t6_done_seen");
    repeat (3) @(posedge clk); #2;
    check("final_sb_drained", 64'(sb_q.size()), 64'd0);
    check("final_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
